// File: rtl/lcd_io_ctrl.sv
// LCD output controller: CPU stores to LCD_ADDR are queued and drained through
// a start/finish handshake; STATUS_ADDR exposes queue and error state.
module lcd_io_ctrl #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned DEPTH       = 4,
  parameter logic [9:0]  LCD_ADDR    = 10'h3FF,
  parameter logic [9:0]  STATUS_ADDR = 10'h3FE,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] lcd_data,
  output logic              start,
  input  logic              finish,
  output logic              go
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              go_q, go_d;

  logic              lcd_hit_s, status_hit_s, full_s, empty_s, busy_s;
  logic              push_s, pop_s, clr_err_s;
  logic [2:0]        count3_s;
  logic              unused_s;

  assign unused_s = ^cpu_wdata[31:DATA_W];

  // Address decode, queue flags and the push/pop/stall qualifiers.
  always_comb begin
    lcd_hit_s    = (cpu_addr == LCD_ADDR);
    status_hit_s = (cpu_addr == STATUS_ADDR);
    full_s       = (count_q == CW'(DEPTH));
    empty_s      = (count_q == {CW{1'b0}});
    busy_s       = (state_q != IDLE);
    push_s       = cpu_we & lcd_hit_s & ~full_s;
    pop_s        = (state_q == IDLE) & ~empty_s;
    clr_err_s    = cpu_we & status_hit_s & cpu_wdata[3];
    cpu_stall    = cpu_we & lcd_hit_s & full_s;
    count3_s     = 3'(count_q);
  end

  // Status readback; zero unless a load hits the status address.
  always_comb begin
    if (cpu_re && status_hit_s) begin
      cpu_rdata = {25'd0, count3_s, err_q, full_s, empty_s, busy_s};
    end else begin
      cpu_rdata = 32'd0;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wptr_q] = cpu_wdata[DATA_W-1:0];
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake sequencing; a timeout drops the word and latches err.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    go_d       = 1'b0;
    timer_d    = timer_q;
    lcd_data_d = lcd_data_q;
    if (clr_err_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          lcd_data_d = mem_q[rptr_q];
          start_d    = 1'b1;
          timer_d    = {TW{1'b0}};
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (finish) begin
          start_d = 1'b0;
          state_d = RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!finish) begin
          go_d    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset acts immediately so start drops mid-handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      timer_q    <= {TW{1'b0}};
      lcd_data_q <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      go_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      lcd_data_q <= lcd_data_d;
      err_q      <= err_d;
      start_q    <= start_d;
      go_q       <= go_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign lcd_data = lcd_data_q;
  assign start    = start_q;
  assign go       = go_q;

endmodule

// File: tb/tb_lcd_io_ctrl.sv
// Bench for lcd_io_ctrl: a cycle-level behavioural model feeds a launch
// scoreboard; a negedge monitor compares outputs and pops on each launch.
module tb_lcd_io_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam logic [9:0] LCD_A  = 10'h3FF;
  localparam logic [9:0] STAT_A = 10'h3FE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  cpu_addr = 10'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [9:0]  lcd_data;
  logic        start;
  logic        finish = 1'b0;
  logic        go;

  int total = 0;
  int bad   = 0;

  int ack_dly = 0;
  int rel_dly = 1;

  // behavioural model state
  logic [9:0] pend[$];
  logic [9:0] exp_launch[$];
  int phase = 0;
  int tmr   = 0;
  bit m_err = 1'b0;
  bit m_go  = 1'b0;
  int go_exp  = 0;
  int go_seen = 0;
  bit prev_start = 1'b0;

  lcd_io_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .lcd_data  (lcd_data),
    .start     (start),
    .finish    (finish),
    .go        (go)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending words plus the handshake phase.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      exp_launch.delete();
      phase = 0;
      tmr   = 0;
      m_err = 1'b0;
      m_go  = 1'b0;
    end else begin
      bit push_ok;
      bit clr;
      push_ok = cpu_we && (cpu_addr == LCD_A) && (pend.size() < DEPTH);
      clr     = cpu_we && (cpu_addr == STAT_A) && cpu_wdata[3];
      m_go = 1'b0;
      if (clr) m_err = 1'b0;
      if (phase == 0) begin
        if (pend.size() > 0) begin
          exp_launch.push_back(pend.pop_front());
          phase = 1;
          tmr   = 0;
        end
      end else if (phase == 1) begin
        if (finish) phase = 2;
        else if (tmr == TIMEOUT - 1) begin
          phase = 0;
          m_err = 1'b1;
        end else tmr++;
      end else begin
        if (!finish) begin
          phase = 0;
          m_go  = 1'b1;
          go_exp++;
        end
      end
      if (push_ok) pend.push_back(cpu_wdata[9:0]);
    end
  end

  // Monitor: per-cycle output checks and scoreboard pop on each launch.
  always @(negedge clk) begin
    if (rst) begin
      logic [31:0] exp_rd;
      int n;
      n = pend.size();
      exp_rd = 32'd0;
      if (cpu_re && cpu_addr == STAT_A)
        exp_rd = {25'd0, 3'(n), m_err, (n == DEPTH), (n == 0), (phase != 0)};
      chk("rdata", cpu_rdata, exp_rd);
      chk("stall", {31'd0, cpu_stall}, {31'd0, (cpu_we && cpu_addr == LCD_A && n == DEPTH)});
      chk("start", {31'd0, start}, {31'd0, (phase == 1)});
      chk("go", {31'd0, go}, {31'd0, m_go});
      if (start && !prev_start) begin
        if (exp_launch.size() == 0) begin
          total++;
          bad++;
          $display("FAIL launch: unexpected start with lcd_data %h", lcd_data);
        end else begin
          chk("lcd_data", {22'd0, lcd_data}, {22'd0, exp_launch.pop_front()});
        end
      end
      if (go) go_seen++;
    end
    prev_start = start;
  end

  // LCD responder: raise finish after ack_dly start cycles, drop rel_dly after start falls.
  initial begin
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        finish = 1'b0;
        hi = 0;
        lo = 0;
      end else if (start) begin
        lo = 0;
        hi++;
        if (ack_dly > 0 && hi > ack_dly) finish = 1'b1;
      end else begin
        hi = 0;
        if (finish) begin
          lo++;
          if (lo >= rel_dly) finish = 1'b0;
        end
      end
    end
  end

  task automatic store(logic [9:0] a, logic [31:0] d, bit retry);
    int tries;
    bit stalled;
    tries = 0;
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    if (retry) begin
      do begin
        @(negedge clk);
        stalled = cpu_stall;
        tries++;
        if (stalled) @(posedge clk);
      end while (stalled && tries < 3000);
      if (stalled) begin
        total++;
        bad++;
        $display("FAIL store_retry: still stalled after %0d cycles", tries);
      end
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic status_chk(string nm, logic [31:0] exp);
    cpu_re = 1'b1;
    cpu_addr = STAT_A;
    @(negedge clk);
    chk(nm, cpu_rdata, exp);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
  endtask

  task automatic wait_drain(int lim);
    int k;
    k = 0;
    while ((phase != 0 || pend.size() != 0) && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (phase != 0 || pend.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: not idle after %0d cycles", lim);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_start(int lim, output int cycles);
    int k;
    k = 0;
    cycles = 0;
    while (!start && k < lim) begin
      @(negedge clk);
      k++;
    end
    while (start && k < lim) begin
      cycles++;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int g0;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk("rst_lcd", {22'd0, lcd_data}, 32'd0);
    rst = 1'b1;
    status_chk("reset_status", 32'h2);

    // single transfer, finish after 2 cycles, release after 1
    ack_dly = 2;
    rel_dly = 1;
    g0 = go_seen;
    store(LCD_A, 32'hABCD_0155, 1'b0);
    measure_start(50, c);
    chk("single_start_cycles", c, 32'd3);
    wait_drain(50);
    chk("single_lcd", {22'd0, lcd_data}, 32'h155);
    chk("single_go", go_seen - g0, 32'd1);
    status_chk("single_status", 32'h2);

    // fill and stall with the LCD silent
    ack_dly = 0;
    for (int i = 0; i < 5; i++) store(LCD_A, 32'h10 + i, 1'b0);
    cpu_we = 1'b1;
    cpu_addr = LCD_A;
    cpu_wdata = 32'h99;
    @(negedge clk);
    chk("fill_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    status_chk("fill_status", 32'h45);
    ack_dly = 1;
    wait_drain(2000);

    // ordering and pointer wrap
    g0 = go_seen;
    for (int i = 0; i < 10; i++) store(LCD_A, $urandom, 1'b1);
    wait_drain(2000);
    chk("order_go", go_seen - g0, 32'd10);

    // timeout
    ack_dly = 0;
    store(LCD_A, 32'h3C0, 1'b0);
    measure_start(400, c);
    chk("timeout_cycles", c, 32'd255);
    @(posedge clk);
    #1;
    status_chk("timeout_err", 32'hA);
    store(STAT_A, 32'h8, 1'b0);
    status_chk("err_cleared", 32'h2);

    // address decode
    store(10'h100, $urandom, 1'b0);
    cpu_re = 1'b1;
    cpu_addr = LCD_A;
    @(negedge clk);
    chk("decode_rdata", cpu_rdata, 32'd0);
    chk("decode_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    status_chk("decode_status", 32'h2);

    // asynchronous reset mid-handshake
    store(LCD_A, 32'h2AA, 1'b0);
    k = 0;
    while (!start && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_start", {31'd0, start}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_start", {31'd0, start}, 32'd0);
    chk("async_rst_lcd", {22'd0, lcd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    status_chk("post_rst_status", 32'h2);

    // randomized traffic
    ack_dly = 1;
    rel_dly = 1;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) store(LCD_A, $urandom, 1'b1);
      else if (r == 5) store(STAT_A, $urandom, 1'b0);
      else if (r == 6) store(10'($urandom_range(0, 1023)), $urandom, 1'b0);
      else if (r == 7) begin
        cpu_re = 1'b1;
        cpu_addr = ($urandom_range(0, 1) == 0) ? STAT_A : 10'($urandom);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
      end else if (r == 8) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end else begin
        ack_dly = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
        rel_dly = $urandom_range(1, 3);
      end
    end
    ack_dly = 1;
    wait_drain(3000);
    chk("go_total", go_seen, go_exp);
    chk("sb_drained", exp_launch.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_io_ctrl.md
Name: lcd_io_ctrl

Overview:
Memory-mapped output controller that sequences the LCD start/finish handshake on behalf of the CPU datapath.
- CPU stores to LCD_ADDR are queued in a small FIFO.
- A handshake FSM drains the queue one word at a time onto lcd_data.
- The CPU stalls only when the queue is full.
- A status register at STATUS_ADDR exposes queue and error state to CPU loads.

Parameters:
DATA_W, 10, width of lcd_data and of each FIFO entry
DEPTH, 4, FIFO entries (power of two, >=2)
LCD_ADDR, 10'h3FF, word address whose stores push to the FIFO
STATUS_ADDR, 10'h3FE, word address of the status/control register
TIMEOUT, 255, max cycles in START waiting for finish before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_addr  in  10  data-memory address from ALU result
cpu_wdata  in  32  store data
cpu_we  in  1  store strobe (MemWrite)
cpu_re  in  1  load strobe (MemRead)
cpu_rdata  out  32  status word on load hit, else 0
cpu_stall  out  1  hold PC/writeback this cycle
lcd_data  out  DATA_W  word presented to LCD
start  out  1  handshake request to LCD
finish  in  1  handshake acknowledge from LCD (synchronous to clk)
go  out  1  one-cycle pulse per completed transfer

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; FIFO empty (count=0, pointers 0); err=0; lcd_data=0; start=0; go=0; timeout counter=0. Takes effect immediately, including mid-handshake: start drops without waiting for a clock edge.
- Push: occurs on a clock edge when cpu_we=1, cpu_addr==LCD_ADDR and full=0. Stores cpu_wdata[DATA_W-1:0]; upper bits are ignored.
- cpu_stall: combinational, equal to cpu_we & (cpu_addr==LCD_ADDR) & full. full is the registered flag (count==DEPTH).
  - A pop in the same cycle does not unblock the push; the CPU retries next cycle.
  - No push occurs while stalled.
- Status write: cpu_we=1, cpu_addr==STATUS_ADDR and cpu_wdata[3]=1 clears err. Other bits are ignored.
- Status read: cpu_rdata = {25'b0, count[2:0], err, full, empty, busy} when cpu_re=1 and cpu_addr==STATUS_ADDR, else 32'b0. Combinational. busy = (state!=IDLE). count uses clog2(DEPTH)+1 bits; bits above are zero.
- Writes to any other address are ignored.
- FSM (all outputs registered):
  - IDLE: if count>0, on the next edge: lcd_data<=head, pop, start<=1, timer<=0, go to START.
  - START: start=1, lcd_data held.
    - If finish=1 is sampled: start<=0, go to RELEASE.
    - Else if timer==TIMEOUT-1: start<=0, err<=1, go to IDLE. The word is dropped.
    - Else timer increments.
  - RELEASE: start=0. When finish=0 is sampled: go<=1 for exactly one cycle, go to IDLE.
- lcd_data holds the last transferred word while idle.
- Minimum transfer is 3 cycles (START, RELEASE, IDLE) when finish responds immediately.
- Latency: a push at edge N with the FSM idle gives start=1 and lcd_data valid after edge N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Back-to-back words: IDLE with count>0 re-launches on the next edge, so there is one IDLE cycle between transfers.
- err is sticky until cleared by software or reset. A new timeout while err=1 leaves err=1.

Test Plan:
- Reset: drive rst=0 mid-START (start=1) -> start=0 immediately without a clock edge. After release, a status read returns 32'h2 (empty=1).
- Single transfer: store 32'hABCD_0155 to 10'h3FF; LCD asserts finish 2 cycles after start and deasserts 1 cycle after start falls -> lcd_data=10'h155, start high exactly 3 cycles, exactly one go pulse, status returns 32'h2.
- Fill and stall: hold finish=0 and store 6 words back-to-back -> first word launches, next 4 fill the FIFO. cpu_stall=1 on the 6th store with no push, and status reads count=4, full=1, busy=1 (32'h45).
- Ordering and wrap: push 10 words while the LCD acks each after 1 cycle -> lcd_data sequence equals the push order and go pulses 10 times.
- Timeout: push 10'h3C0, never assert finish -> start drops after 255 cycles, status bit3=1. A store of 32'h8 to 10'h3FE clears err -> status returns 32'h2.
- Address decode: store to 10'h100 and load from 10'h3FF -> no push, cpu_rdata=0, cpu_stall=0.
